// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin share of the regfile write port between the ALU (A)
//           and load (B) writeback paths, plus a per-register pending-write
//           scoreboard for hazard checks.
// Revision: 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [ASIZE-1:0] a_addr,
  input  logic [DSIZE-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [ASIZE-1:0] b_addr,
  input  logic [DSIZE-1:0] b_data,
  output logic             b_ready,
  input  logic             wb_hold,
  input  logic             iss_valid,
  input  logic [ASIZE-1:0] iss_addr,
  output logic             iss_ready,
  input  logic             flush,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic [NREG-1:0]  busy_vec,
  output logic             sb_err
);

  localparam logic [0:0] c_RR_A = 1'b0;
  localparam logic [0:0] c_RR_B = 1'b1;

  logic [0:0]       r_rr_last;
  logic             r_wen;
  logic [ASIZE-1:0] r_waddr;
  logic [DSIZE-1:0] r_wdata;
  logic             r_sb_err;
  logic [1:0]       r_cnt [NREG];

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_xfer;
  logic [ASIZE-1:0] w_xaddr;
  logic [DSIZE-1:0] w_xdata;
  logic             w_iss_fire;
  logic             w_dec_err;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;

  // Contention goes to whichever side was not served last.
  assign w_grant_a = !wb_hold && a_valid && (!b_valid || (r_rr_last == c_RR_B));
  assign w_grant_b = !wb_hold && b_valid && (!a_valid || (r_rr_last == c_RR_A));
  assign w_xfer    = w_grant_a || w_grant_b;
  assign w_xaddr   = w_grant_a ? a_addr : b_addr;
  assign w_xdata   = w_grant_a ? a_data : b_data;

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_last <= c_RR_B;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_grant_a) begin
        r_rr_last <= c_RR_A;
      end else if (w_grant_b) begin
        r_rr_last <= c_RR_B;
      end
      // Writes to x0 complete the handshake but never reach the regfile.
      r_wen <= w_xfer && (w_xaddr != '0);
      if (w_xfer && (w_xaddr != '0)) begin
        r_waddr <= w_xaddr;
        r_wdata <= w_xdata;
      end
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

  // A retiring write in the same cycle frees a slot in a saturated counter.
  assign iss_ready  = (iss_addr == '0) || (r_cnt[iss_addr] != 2'd3) ||
                      (r_wen && (r_waddr == iss_addr));
  assign w_iss_fire = iss_valid && iss_ready && (iss_addr != '0);
  assign w_dec_err  = r_wen && (r_cnt[r_waddr] == 2'd0);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      assign w_inc[gi] = w_iss_fire && (iss_addr == ASIZE'(gi));
      assign w_dec[gi] = r_wen && (r_waddr == ASIZE'(gi));
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_busy
        assign busy_vec[gi] = (r_cnt[gi] != 2'd0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (flush) begin
          r_cnt[i] <= 2'd0;
        end else if (w_inc[i] && !w_dec[i] && (r_cnt[i] != 2'd3)) begin
          r_cnt[i] <= r_cnt[i] + 2'd1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 2'd0)) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_err <= 1'b0;
    end else if (w_dec_err) begin
      r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed stimulus for regfile_wb_arbiter; expected writes are
//           queued at issue time and matched by an independent write monitor.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        wb_hold = 1'b0, iss_valid = 1'b0, flush = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        iss_ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy_vec;
  logic        sb_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stp    = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  regfile_wb_arbiter #(.DSIZE(32), .ASIZE(5), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wb_hold(wb_hold), .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .flush(flush), .wen(wen), .waddr(waddr), .wdata(wdata),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Write monitor: every regfile write must match the oldest queued one, on time.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: actual waddr=%0d wdata=%08h required no write", waddr, wdata);
      end else begin
        mon_e = expq.pop_front();
        if (waddr !== mon_e.addr || wdata !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL wr_match: actual addr=%0d data=%08h cyc=%0d required addr=%0d data=%08h cyc=%0d",
                   waddr, wdata, cyc, mon_e.addr, mon_e.data, mon_e.due);
        end
      end
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      checks++;
      errors++;
      mon_e = expq.pop_front();
      $display("FAIL wr_missing: actual wen=%b required write addr=%0d data=%08h", wen, mon_e.addr, mon_e.data);
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic hold, input logic iv, input logic [4:0] ia, input logic fl,
                      input logic ear, input logic ebr, input logic eir);
    stp++;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wb_hold = hold; iss_valid = iv; iss_addr = ia; flush = fl;
    #3;
    chk($sformatf("a_ready[s%0d]", stp), a_ready, ear);
    chk($sformatf("b_ready[s%0d]", stp), b_ready, ebr);
    chk($sformatf("iss_ready[s%0d]", stp), iss_ready, eir);
    if (ear && aa != 5'd0) expq.push_back('{addr: aa, data: ad, due: cyc + 1});
    if (ebr && ba != 5'd0) expq.push_back('{addr: ba, data: bd, due: cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic eir);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_wen_async", wen, 0);
    chk("rst_sb_err_async", sb_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_sb_err", sb_err, 0);

    // Reserve r3 and r4 three times each so the following writes retire cleanly.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 1);
    chk("busy_r3r4", busy_vec, 32'h18);

    // Both requesting: A first after reset, then strict alternation.
    step(1, 3, 32'hA000_0001, 1, 4, 32'hB000_0001, 0, 0, 0, 0, 1, 0, 1);
    step(1, 3, 32'hA000_0002, 1, 4, 32'hB000_0001, 0, 0, 0, 0, 0, 1, 1);
    step(1, 3, 32'hA000_0002, 1, 4, 32'hB000_0002, 0, 0, 0, 0, 1, 0, 1);
    step(1, 3, 32'hA000_0003, 1, 4, 32'hB000_0002, 0, 0, 0, 0, 0, 1, 1);

    // Hold blocks both; afterwards A resumes since B was served last.
    step(1, 3, 32'hA000_0003, 1, 4, 32'hB000_0003, 1, 0, 0, 0, 0, 0, 1);
    chk("hold_wen", wen, 0);
    step(1, 3, 32'hA000_0003, 1, 4, 32'hB000_0003, 1, 0, 0, 0, 0, 0, 1);
    chk("hold_wen2", wen, 0);
    step(1, 3, 32'hA000_0003, 1, 4, 32'hB000_0003, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0,             1, 4, 32'hB000_0003, 0, 0, 0, 0, 0, 1, 1);

    // Write to x0 is accepted but suppressed.
    step(0, 0, 0, 1, 0, 32'h0000_DEAD, 0, 0, 0, 0, 0, 1, 1);
    chk("x0_wen", wen, 0);
    chk("x0_busy", busy_vec, 0);
    chk("x0_sb_err", sb_err, 0);

    // r5: fill to saturation, then retire and re-reserve in the same cycle.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1);
    chk("busy_r5", busy_vec, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0);
    step(1, 5, 32'h5555_0005, 0, 0, 0, 0, 0, 5'd5, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1);
    chk("busy_r5_full", busy_vec, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0);

    // Retire to r7 with nothing pending sets the sticky error.
    step(1, 7, 32'h7777_0007, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("err_before", sb_err, 0);
    idle(1);
    chk("err_set", sb_err, 1);
    chk("err_busy", busy_vec, 32'h20);
    idle(1);
    chk("err_sticky", sb_err, 1);

    // Flush wins over a same-cycle reservation and leaves sb_err alone.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 1, 0, 0, 1);
    chk("flush_busy", busy_vec, 0);
    chk("flush_sb_err", sb_err, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1);
    chk("post_flush_busy", busy_vec, 32'h20);

    // Asynchronous reset while a write is on the port.
    a_valid = 1; a_addr = 5'd9; a_data = 32'h9999_0009;
    iss_valid = 1; iss_addr = 5'd9;
    #3;
    chk("pre_rst_a_ready", a_ready, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_wen", wen, 1);
    chk("pre_rst_waddr", waddr, 9);
    chk("pre_rst_busy", busy_vec, 32'h220);
    a_valid = 0; iss_valid = 0;
    rst = 1'b0;
    #1;
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_sb_err", sb_err, 0);
    chk("mid_rst_busy", busy_vec, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
